cnoc_request_deserializer: RTL

- Receive-side counterpart of the CNOC indication serializer.
- Accepts a 32-bit word stream of messages, each a header word followed by payload words, and routes the payload words to per-method request channels.
- Sits between the host-facing request message port and the request-input block's requests_N_enq interfaces.
- Drops malformed messages and counts them.

---
 rtl/cnoc_request_deserializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cnoc_request_deserializer.sv
// rtl/cnoc_request_deserializer.sv - header/payload word stream to per-method request channels
// Parses header words, forwards payload through a one-entry output buffer, drops malformed messages.
module cnoc_request_deserializer #(
  parameter int NUM_METHODS = 3,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            message_enq_v,
  input  logic                   EN_message_enq,
  output logic                   RDY_message_enq,
  output logic [31:0]            requests_enq_v,
  output logic                   requests_last,
  output logic [NUM_METHODS-1:0] EN_requests_enq,
  input  logic [NUM_METHODS-1:0] RDY_requests_enq,
  output logic [15:0]            msg_count,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic                   busy
);

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_PAY  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [7:0]           method_q, method_d;
  logic [15:0]          words_left_q, words_left_d;
  logic                 obuf_valid_q, obuf_valid_d;
  logic [31:0]          obuf_data_q, obuf_data_d;
  logic [7:0]           obuf_method_q, obuf_method_d;
  logic                 obuf_last_q, obuf_last_d;
  logic [15:0]          msg_count_q, msg_count_d;
  logic [ERR_WIDTH-1:0] err_count_q, err_count_d;

  logic        fire;
  logic        accept;
  logic        err_inc;
  logic [15:0] hdr_method;
  logic [15:0] hdr_len;
  logic        hdr_legal;

  assign hdr_method = message_enq_v[31:16];
  assign hdr_len    = message_enq_v[15:0];
  // Full 16-bit compare, so any set bit in [31:24] makes the method illegal.
  assign hdr_legal  = (hdr_method < 16'(NUM_METHODS));

  always_comb begin
    fire            = 1'b0;
    EN_requests_enq = '0;
    for (int i = 0; i < NUM_METHODS; i++) begin
      if (obuf_valid_q && (obuf_method_q == 8'(i)) && RDY_requests_enq[i]) begin
        fire               = 1'b1;
        EN_requests_enq[i] = 1'b1;
      end
    end
  end

  assign RDY_message_enq = (state_q != ST_PAY) || !obuf_valid_q || fire;
  assign accept          = EN_message_enq && RDY_message_enq;
  assign requests_enq_v  = obuf_data_q;
  assign requests_last   = obuf_last_q;
  assign msg_count       = msg_count_q;
  assign err_count       = err_count_q;
  assign busy            = (state_q != ST_HDR) || obuf_valid_q;

  always_comb begin
    state_d       = state_q;
    method_d      = method_q;
    words_left_d  = words_left_q;
    obuf_valid_d  = obuf_valid_q && !fire;
    obuf_data_d   = obuf_data_q;
    obuf_method_d = obuf_method_q;
    obuf_last_d   = obuf_last_q;
    msg_count_d   = msg_count_q;
    err_count_d   = err_count_q;
    err_inc       = 1'b0;
    if (accept) begin
      case (state_q)
        ST_HDR: begin
          if (hdr_len == 16'd0) begin
            err_inc = 1'b1;
          end else if (!hdr_legal) begin
            err_inc = 1'b1;
            if (hdr_len > 16'd1) begin
              state_d      = ST_DROP;
              words_left_d = hdr_len - 16'd1;
            end
          end else if (hdr_len == 16'd1) begin
            msg_count_d = msg_count_q + 16'd1;
          end else begin
            method_d     = hdr_method[7:0];
            words_left_d = hdr_len - 16'd1;
            state_d      = ST_PAY;
          end
        end
        ST_PAY: begin
          obuf_valid_d  = 1'b1;
          obuf_data_d   = message_enq_v;
          obuf_method_d = method_q;
          obuf_last_d   = (words_left_q == 16'd1);
          words_left_d  = words_left_q - 16'd1;
          if (words_left_q == 16'd1) begin
            msg_count_d = msg_count_q + 16'd1;
            state_d     = ST_HDR;
          end
        end
        ST_DROP: begin
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) begin
            state_d = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
    if (err_inc && (err_count_q != {ERR_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_HDR;
      method_q      <= 8'd0;
      words_left_q  <= 16'd0;
      obuf_valid_q  <= 1'b0;
      obuf_data_q   <= 32'd0;
      obuf_method_q <= 8'd0;
      obuf_last_q   <= 1'b0;
      msg_count_q   <= 16'd0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      method_q      <= method_d;
      words_left_q  <= words_left_d;
      obuf_valid_q  <= obuf_valid_d;
      obuf_data_q   <= obuf_data_d;
      obuf_method_q <= obuf_method_d;
      obuf_last_q   <= obuf_last_d;
      msg_count_q   <= msg_count_d;
      err_count_q   <= err_count_d;
    end
  end

endmodule
